// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller interface blocks.
package snes_pkg;

  localparam int SNES_FRAME_BITS = 16;

  // Report bit positions, matching the order the pad shifts them out.
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs (pad data, IR, keyboard).
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// Console-side SNES pad reader: drives latch/clock, shifts in the 16-bit report.
// Optional SNES_READER_FILTER_EN: publish only when two consecutive raw frames agree.
module snes_pad_reader
  import snes_pkg::*;
#(
  parameter int LATCH_CYCLES = 25,
  parameter int HALF_CYCLES  = 12,
  parameter int POLL_CYCLES  = 34667
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        snes_data_i,
  output logic        snes_latch_o,
  output logic        snes_clk_o,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        pad_ok,
  output logic        busy
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int PULSE_W   = $clog2(SNES_FRAME_BITS);
  localparam int POLL_W    = $clog2(POLL_CYCLES + 1);

  state_t                     state_q, state_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic [PULSE_W-1:0]         pulse_q, pulse_d;
  logic [POLL_W-1:0]          poll_q;
  logic [SNES_FRAME_BITS-1:0] raw_q;
  logic                       data_s;
  logic                       phase_last, poll_expired;
  logic                       sample_en, frame_end, poll_start, publish;

  sync_2ff #(.RESET_VAL(1'b1)) u_data_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (snes_data_i),
    .q       (data_s)
  );

  assign phase_last   = (phase_q == '0);
  assign poll_expired = (poll_q == '0);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pulse_d    = pulse_q;
    sample_en  = 1'b0;
    frame_end  = 1'b0;
    poll_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && poll_expired) begin
          state_d    = LATCH;
          phase_d    = PHASE_W'(LATCH_CYCLES - 1);
          pulse_d    = '0;
          poll_start = 1'b1;
        end
      end
      LATCH: begin
        if (phase_last) begin
          sample_en = 1'b1;
          state_d   = CLK_LO;
          phase_d   = PHASE_W'(HALF_CYCLES - 1);
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      CLK_LO: begin
        if (phase_last) begin
          state_d = CLK_HI;
          phase_d = PHASE_W'(HALF_CYCLES - 1);
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      CLK_HI: begin
        if (phase_last) begin
          // The last pulse only clocks out the final bit; nothing left to sample.
          if (pulse_q == PULSE_W'(SNES_FRAME_BITS - 1)) begin
            state_d   = DONE;
            frame_end = 1'b1;
          end else begin
            sample_en = 1'b1;
            pulse_d   = pulse_q + PULSE_W'(1);
            state_d   = CLK_LO;
            phase_d   = PHASE_W'(HALF_CYCLES - 1);
          end
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  // Poll interval is measured from latch rise to latch rise; zero means "due".
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      poll_q <= '0;
    end else if (poll_start) begin
      poll_q <= POLL_W'(POLL_CYCLES - 1);
    end else if (!poll_expired) begin
      poll_q <= poll_q - POLL_W'(1);
    end
  end

  // First sample enters at the top and ends up in bit 0 after 16 shifts.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      raw_q <= '0;
    end else if (sample_en) begin
      raw_q <= {data_s, raw_q[SNES_FRAME_BITS-1:1]};
    end
  end

`ifdef SNES_READER_FILTER_EN
  logic [SNES_FRAME_BITS-1:0] prev_q;
  logic                       have_prev_q;

  assign publish = have_prev_q && (raw_q == prev_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else if (frame_end) begin
      prev_q      <= raw_q;
      have_prev_q <= 1'b1;
    end
  end
`else
  assign publish = 1'b1;
`endif

  // Pad-facing pins are registered from the next state so they never glitch.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snes_latch_o <= 1'b0;
      snes_clk_o   <= 1'b1;
      busy         <= 1'b0;
      valid        <= 1'b0;
      buttons      <= '0;
      pad_ok       <= 1'b0;
    end else begin
      snes_latch_o <= (state_d == LATCH);
      snes_clk_o   <= (state_d != CLK_LO);
      busy         <= (state_d != IDLE);
      valid        <= frame_end && publish;
      if (frame_end) begin
        pad_ok <= &raw_q[15:12];
        if (publish) begin
          buttons <= ~raw_q;
        end
      end
    end
  end

endmodule
